// File: rtl/bit_count_engine.sv
// Sequential bit-count engine: popcount / zero count / leading and
// trailing zeros, processing BITS_PER_CYC bits per RUN cycle.
module bit_count_engine #(
  parameter int DATA_W       = 8,
  parameter int BITS_PER_CYC = 1,
  parameter int CNT_W        = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [CNT_W-1:0]  cnt,
  output logic              rdy,
  output logic              done
);

  localparam int B      = BITS_PER_CYC;
  localparam int NCHUNK = DATA_W / B;
  localparam int CHK_W  = $clog2(NCHUNK + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] w;
  logic              lz_path;
  logic [CHK_W-1:0]  chunk;

  logic [B-1:0]      top_s;
  logic [DATA_W-1:0] w_nxt;
  logic [DATA_W-1:0] w_shr;
  logic [CHK_W-1:0]  chunk_inc;
  logic [CNT_W-1:0]  cnt_add;
  logic              last;
  logic              fin;
  logic [DATA_W-1:0] w_load;

  function automatic logic [CNT_W-1:0] pop_chunk(
    input logic [B-1:0] s
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < B; i++)
      n = n + CNT_W'(s[i]);
    return n;
  endfunction

  // Leading zeros of a nonzero chunk, counted from its MSB.
  function automatic logic [CNT_W-1:0] lz_chunk(
    input logic [B-1:0] s
  );
    logic [CNT_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = B - 1; i >= 0; i--) begin
      if (!hit) begin
        if (s[i]) hit = 1'b1;
        else      n   = n + CNT_W'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] bit_rev(
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++)
      r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  assign rdy = (state == S_IDLE);

  // Operand transform applied at load time.
  always_comb begin
    unique case (mode)
      2'b01:   w_load = ~data_in;
      2'b11:   w_load = bit_rev(data_in);
      default: w_load = data_in;
    endcase
  end

  // One RUN step: count contribution, next work word, exit test.
  always_comb begin
    top_s     = w[DATA_W-1 -: B];
    w_shr     = w >> B;
    chunk_inc = chunk + CHK_W'(1);
    last      = (chunk_inc == CHK_W'(NCHUNK));
    cnt_add   = '0;
    w_nxt     = w;
    fin       = 1'b0;
    if (lz_path) begin
      if (top_s == '0) begin
        cnt_add = CNT_W'(B);
        w_nxt   = w << B;
        fin     = last;
      end else begin
        cnt_add = lz_chunk(top_s);
        fin     = 1'b1;
      end
    end else begin
      cnt_add = pop_chunk(w[B-1:0]);
      w_nxt   = w_shr;
      fin     = (w_shr == '0) || last;
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      w       <= '0;
      lz_path <= 1'b0;
      cnt     <= '0;
      chunk   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            w       <= w_load;
            lz_path <= mode[1];
            cnt     <= '0;
            chunk   <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          cnt   <= cnt + cnt_add;
          w     <= w_nxt;
          chunk <= chunk_inc;
          if (fin) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
